// File: rtl/sun_apb_master.sv
// sun_apb_master: APB sequencer that configures a pixel engine, streams
// pixels into it, polls its status and reads back the h/k results.
module sun_apb_master #(
  parameter int TIMEOUT  = 16,
  parameter int POLL_MAX = 255,
  parameter int RD_WAIT  = 2
) (
  input  logic        pclk,
  input  logic        presetn,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        start,
  input  logic [7:0]  thr,
  input  logic [7:0]  xmax,
  input  logic [7:0]  ymax,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] h,
  output logic [31:0] k,
  output logic [7:0]  last_status
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CTRL, S_WR_THR, S_WR_XMAX,
    S_WR_YMAX, S_WAIT_PIX, S_WR_PIX, S_POLL,
    S_RD_H, S_RD_K, S_DONE
  } state_t;

  // GAP keeps psel low for one cycle between transfers
  typedef enum logic [1:0] {
    P_GAP, P_SETUP, P_ACC
  } phase_t;

  state_t      state, state_n;
  phase_t      ph, ph_n;
  logic [15:0] acc_cnt;
  logic [15:0] poll_cnt;
  logic [15:0] n;
  logic [7:0]  thr_q, xmax_q, ymax_q, pix_q;
  logic [7:0]  st;
  logic        xfer, is_rd, fin, tmo;
  logic        poll_ok, poll_fail, bad_dim;

  assign st      = prdata[7:0];
  assign bad_dim = (xmax == 8'd0) || (ymax == 8'd0);
  assign xfer    = state inside {S_WR_CTRL, S_WR_THR,
                   S_WR_XMAX, S_WR_YMAX, S_WR_PIX,
                   S_POLL, S_RD_H, S_RD_K};
  assign is_rd   = state inside {S_POLL, S_RD_H, S_RD_K};
  assign fin     = xfer && (ph == P_ACC) &&
                   (pready || (is_rd &&
                   acc_cnt == 16'(RD_WAIT - 1)));
  assign tmo     = xfer && (ph == P_ACC) && !fin &&
                   acc_cnt == 16'(TIMEOUT - 1);
  assign poll_ok = (n != 16'd0 && st == 8'h02) ||
                   (n == 16'd0 && st == 8'h48);
  assign poll_fail = (state == S_POLL) && fin &&
                     !poll_ok &&
                     poll_cnt == 16'(POLL_MAX - 1);

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state <= S_IDLE;
      ph    <= P_GAP;
    end else begin
      state <= state_n;
      ph    <= ph_n;
    end
  end

  always_comb begin
    state_n = state;
    ph_n    = ph;
    if (state == S_IDLE) begin
      if (start)
        state_n = bad_dim ? S_DONE : S_WR_CTRL;
    end else if (state == S_WAIT_PIX) begin
      if (pix_valid)
        state_n = S_WR_PIX;
    end else if (state == S_DONE) begin
      state_n = S_IDLE;
    end else begin
      case (ph)
        P_GAP:   ph_n = P_SETUP;
        P_SETUP: ph_n = P_ACC;
        default: begin
          if (tmo || poll_fail) begin
            state_n = S_DONE;
            ph_n    = P_GAP;
          end else if (fin) begin
            ph_n = P_GAP;
            case (state)
              S_WR_CTRL: state_n = S_WR_THR;
              S_WR_THR:  state_n = S_WR_XMAX;
              S_WR_XMAX: state_n = S_WR_YMAX;
              S_WR_YMAX: state_n = S_WAIT_PIX;
              S_WR_PIX:  state_n = S_POLL;
              S_POLL: begin
                if (poll_ok)
                  state_n = (n != 16'd0) ?
                            S_WAIT_PIX : S_RD_H;
              end
              S_RD_H:  state_n = S_RD_K;
              default: state_n = S_DONE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      acc_cnt     <= '0;
      poll_cnt    <= '0;
      n           <= '0;
      thr_q       <= '0;
      xmax_q      <= '0;
      ymax_q      <= '0;
      pix_q       <= '0;
      err         <= 1'b0;
      h           <= '0;
      k           <= '0;
      last_status <= '0;
    end else begin
      if (ph == P_SETUP)
        acc_cnt <= '0;
      else if (ph == P_ACC)
        acc_cnt <= acc_cnt + 16'd1;
      if (state == S_IDLE && start) begin
        thr_q       <= thr;
        xmax_q      <= xmax;
        ymax_q      <= ymax;
        n           <= {8'd0, xmax} * {8'd0, ymax};
        err         <= bad_dim;
        h           <= '0;
        k           <= '0;
        last_status <= '0;
      end
      if (tmo || poll_fail)
        err <= 1'b1;
      if (state == S_WAIT_PIX && pix_valid)
        pix_q <= pix_data;
      if (fin && state == S_WR_PIX) begin
        n        <= n - 16'd1;
        poll_cnt <= '0;
      end
      if (fin && state == S_POLL) begin
        last_status <= st;
        poll_cnt    <= poll_cnt + 16'd1;
      end
      if (fin && state == S_RD_H)
        h <= prdata;
      if (fin && state == S_RD_K)
        k <= prdata;
    end
  end

  always_comb begin
    psel      = xfer && (ph != P_GAP);
    penable   = xfer && (ph == P_ACC);
    pwrite    = 1'b0;
    paddr     = '0;
    pwdata    = '0;
    pix_ready = (state == S_WAIT_PIX);
    busy      = (state != S_IDLE) &&
                (state != S_DONE);
    done      = (state == S_DONE);
    case (state)
      S_WR_CTRL: begin
        pwrite = 1'b1;
        pwdata = 32'h1;
      end
      S_WR_THR: begin
        pwrite = 1'b1;
        paddr  = 32'h1;
        pwdata = {24'd0, thr_q};
      end
      S_WR_XMAX: begin
        pwrite = 1'b1;
        paddr  = 32'h2;
        pwdata = {24'd0, xmax_q};
      end
      S_WR_YMAX: begin
        pwrite = 1'b1;
        paddr  = 32'h3;
        pwdata = {24'd0, ymax_q};
      end
      S_WR_PIX: begin
        pwrite = 1'b1;
        paddr  = 32'h4;
        pwdata = {24'd0, pix_q};
      end
      S_POLL:  paddr = 32'h5;
      S_RD_H:  paddr = 32'h8;
      S_RD_K:  paddr = 32'h9;
      default: paddr = '0;
    endcase
  end

endmodule

// File: tb/tb_sun_apb_master.sv
// tb_sun_apb_master: directed checks of the APB sequencer against
// a small slave model with hand-computed transfer logs.
module tb_sun_apb_master;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready;
  logic        start;
  logic [7:0]  thr, xmax, ymax;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready, busy, done, err;
  logic [31:0] h, k;
  logic [7:0]  last_status;

  always #5 pclk = ~pclk;

  sun_apb_master dut (
    .pclk(pclk), .presetn(presetn),
    .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .start(start),
    .thr(thr), .xmax(xmax), .ymax(ymax),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .busy(busy),
    .done(done), .err(err), .h(h), .k(k),
    .last_status(last_status)
  );

  int n_run = 0;
  int n_fail = 0;
  logic stuck = 1'b0;
  logic hang_thr = 1'b0;
  int npix_exp = 4;
  int npix_wr, done_cnt, psel_cnt;
  int thr_acc, rd5_cnt, proto_err;
  logic [40:0] log_q[$];
  logic        p_sel = 1'b0, p_en = 1'b0;
  logic        p_rdy = 1'b0, p_wr = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;

  localparam logic [40:0] EXP1 [14] = '{
    {1'b1, 8'h00, 32'h01}, {1'b1, 8'h01, 32'h10},
    {1'b1, 8'h02, 32'h02}, {1'b1, 8'h03, 32'h02},
    {1'b1, 8'h04, 32'h20}, {1'b0, 8'h05, 32'h00},
    {1'b1, 8'h04, 32'h05}, {1'b0, 8'h05, 32'h00},
    {1'b1, 8'h04, 32'h30}, {1'b0, 8'h05, 32'h00},
    {1'b1, 8'h04, 32'h40}, {1'b0, 8'h05, 32'h00},
    {1'b0, 8'h08, 32'h00}, {1'b0, 8'h09, 32'h00}
  };

  assign pready = psel && penable &&
                  !(hang_thr && paddr == 32'h1);

  always_comb begin
    prdata = 32'hdead_0000;
    case (paddr)
      32'h5: prdata = stuck ? 32'h03 :
               (npix_wr < npix_exp ? 32'h02 : 32'h48);
      32'h8: prdata = 32'h1;
      32'h9: prdata = 32'h2;
      default: prdata = 32'hdead_0000;
    endcase
  end

  always @(negedge pclk) begin
    if (psel && penable && pready) begin
      log_q.push_back({pwrite, paddr[7:0],
                       pwrite ? pwdata : 32'h0});
      if (pwrite && paddr == 32'h4) npix_wr++;
      if (!pwrite && paddr == 32'h5) rd5_cnt++;
    end
    if (psel && penable && paddr == 32'h1) thr_acc++;
    if (psel) psel_cnt++;
    if (done) done_cnt++;
    if (penable && !psel) proto_err++;
    if (presetn) begin
      if (p_sel && !p_en && !(psel && penable))
        proto_err++;
      if (p_sel && (!p_en || !p_rdy) && psel &&
          (paddr != p_addr || pwrite != p_wr ||
           pwdata != p_wdata))
        proto_err++;
      if (p_sel && p_en && p_rdy && psel)
        proto_err++;
    end
    p_sel   = psel;
    p_en    = penable;
    p_rdy   = pready;
    p_wr    = pwrite;
    p_addr  = paddr;
    p_wdata = pwdata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h",
               tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    npix_wr   = 0;
    done_cnt  = 0;
    psel_cnt  = 0;
    thr_acc   = 0;
    rd5_cnt   = 0;
    proto_err = 0;
    log_q.delete();
  endtask

  task automatic kick(input logic [7:0] t,
                      input logic [7:0] x,
                      input logic [7:0] y);
    thr   = t;
    xmax  = x;
    ymax  = y;
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] p);
    int i = 0;
    while (!pix_ready && i < 200) begin
      @(negedge pclk);
      i++;
    end
    chk("pix_ready_wait", 32'(pix_ready), 1);
    pix_valid = 1'b1;
    pix_data  = p;
    @(negedge pclk);
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done && i < budget) begin
      @(negedge pclk);
      i++;
    end
    chk("done_seen", 32'(done), 1);
    @(negedge pclk);
    #1;
  endtask

  task automatic frame1();
    kick(8'h10, 8'd2, 8'd2);
    send_pix(8'h20);
    send_pix(8'h05);
    send_pix(8'h30);
    send_pix(8'h40);
    wait_done(500);
  endtask

  task automatic check_frame1();
    logic [40:0] e, x;
    chk("f1_log_len", 32'(log_q.size()), 14);
    for (int j = 0; j < 14; j++) begin
      x = EXP1[j];
      e = (j < log_q.size()) ? log_q[j] : '1;
      chk($sformatf("f1_ctl%0d", j),
          32'(e[40:32]), 32'(x[40:32]));
      chk($sformatf("f1_dat%0d", j),
          e[31:0], x[31:0]);
    end
    chk("f1_done_cnt", 32'(done_cnt), 1);
    chk("f1_err", 32'(err), 0);
    chk("f1_h", h, 32'h1);
    chk("f1_k", k, 32'h2);
    chk("f1_busy", 32'(busy), 0);
    chk("f1_status", 32'(last_status), 32'h48);
    chk("f1_proto", 32'(proto_err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int dc;
    int i;
    start     = 1'b0;
    thr       = '0;
    xmax      = '0;
    ymax      = '0;
    pix_valid = 1'b0;
    pix_data  = '0;
    clr_stats();
    repeat (3) @(negedge pclk);
    chk("rst_ctl", 32'({psel, penable, pwrite,
        pix_ready, busy, done, err}), 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_h", h, 0);
    chk("rst_k", k, 0);
    chk("rst_status", 32'(last_status), 0);
    presetn = 1'b1;
    @(negedge pclk);

    clr_stats();
    npix_exp = 4;
    frame1();
    check_frame1();

    clr_stats();
    hang_thr = 1'b1;
    kick(8'h10, 8'd2, 8'd2);
    wait_done(300);
    chk("to_acc_cycles", 32'(thr_acc), 16);
    chk("to_err", 32'(err), 1);
    chk("to_done_cnt", 32'(done_cnt), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_log_len", 32'(log_q.size()), 1);
    hang_thr = 1'b0;

    clr_stats();
    stuck    = 1'b1;
    npix_exp = 1;
    kick(8'h10, 8'd1, 8'd1);
    send_pix(8'h77);
    wait_done(2000);
    chk("poll_reads", 32'(rd5_cnt), 255);
    chk("poll_err", 32'(err), 1);
    chk("poll_status", 32'(last_status), 32'h03);
    chk("poll_done_cnt", 32'(done_cnt), 1);
    chk("poll_busy", 32'(busy), 0);
    stuck = 1'b0;

    clr_stats();
    kick(8'h10, 8'd0, 8'd5);
    chk("zero_done", 32'(done), 1);
    chk("zero_err", 32'(err), 1);
    chk("zero_busy", 32'(busy), 0);
    repeat (5) @(negedge pclk);
    #1;
    chk("zero_psel", 32'(psel_cnt), 0);
    chk("zero_done_cnt", 32'(done_cnt), 1);

    clr_stats();
    npix_exp = 1;
    kick(8'h33, 8'd1, 8'd1);
    i = 0;
    while (!pix_ready && i < 200) begin
      @(negedge pclk);
      i++;
    end
    bad = 0;
    repeat (50) begin
      @(negedge pclk);
      if (psel || !pix_ready) bad++;
    end
    chk("idle_pix_bad", 32'(bad), 0);
    chk("idle_err", 32'(err), 0);
    chk("idle_busy", 32'(busy), 1);
    send_pix(8'h99);
    wait_done(300);
    chk("idle_fin_err", 32'(err), 0);
    chk("idle_h", h, 32'h1);
    chk("idle_k", k, 32'h2);
    chk("idle_done_cnt", 32'(done_cnt), 1);

    clr_stats();
    npix_exp = 4;
    kick(8'h10, 8'd2, 8'd2);
    send_pix(8'h20);
    send_pix(8'h05);
    i = 0;
    while (!(psel && penable && paddr == 32'h4 &&
             pwdata == 32'h05) && i < 300) begin
      @(negedge pclk);
      i++;
    end
    chk("mid_found", 32'(psel && penable), 1);
    chk("mid_status", 32'(last_status), 32'h02);
    #1;
    dc = done_cnt;
    presetn = 1'b0;
    @(negedge pclk);
    #1;
    chk("mid_ctl", 32'({psel, penable, pwrite,
        pix_ready, busy, done, err}), 0);
    chk("mid_paddr", paddr, 0);
    chk("mid_pwdata", pwdata, 0);
    chk("mid_hk", h | k, 0);
    chk("mid_status0", 32'(last_status), 0);
    presetn = 1'b1;
    @(negedge pclk);
    #1;
    chk("mid_no_done", 32'(done_cnt), 32'(dc));

    clr_stats();
    npix_exp = 4;
    frame1();
    check_frame1();

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
